// File: rtl/stereo_pkg.sv
// Shared constants, FSM encoding and address-tag type for the stereo disparity scanner.
// Constants only: no logic, no latency, no backpressure.
package stereo_pkg;

  localparam int WIN_W  = 79;
  localparam int WIN_H  = 16;
  localparam int DEPTH  = 1264;
  localparam int DISP_W = 12;
  localparam int ADDR_W = 11;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 4;
  localparam int CNT_W  = 5;
  localparam int PIX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             vld;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } tag_t;

  function automatic logic signed [DISP_W-1:0] disparity(input logic [COL_W-1:0] cl,
                                                         input logic [COL_W-1:0] cr);
    return $signed({{(DISP_W-COL_W){1'b0}}, cl}) - $signed({{(DISP_W-COL_W){1'b0}}, cr});
  endfunction

endpackage

// File: rtl/marker_find.sv
// First-marker latch for one camera within the current row; found_o/col_o already include
// the sample presented this cycle, so a marker in the last column still counts.
module marker_find
  import stereo_pkg::*;
#(
  parameter logic [PIX_W-1:0] THRESH = 3'd4
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic             last_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [PIX_W-1:0] q_i,
  output logic             found_o,
  output logic [COL_W-1:0] col_o
);

  logic             found_q, found_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             hit;

  always_comb begin
    hit     = vld_i && (q_i >= THRESH);
    found_o = found_q || hit;
    col_o   = found_q ? col_q : col_i;
    found_d = found_q;
    col_d   = col_q;
    if (clr_i) begin
      found_d = 1'b0;
      col_d   = '0;
    end else if (vld_i && last_i) begin
      // Row closes here; the top consumes found_o/col_o this same cycle.
      found_d = 1'b0;
    end else if (hit && !found_q) begin
      found_d = 1'b1;
      col_d   = col_i;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      found_q <= 1'b0;
      col_q   <= '0;
    end else begin
      found_q <= found_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: rtl/stereo_disparity.sv
// Scans both calc RAMs once per start, pairing each read sample with its column/row tag,
// and accumulates the signed per-row marker disparity; done arrives DEPTH+RD_LAT cycles after start.
module stereo_disparity #(
  parameter int         RD_LAT   = 2,
  parameter logic [2:0] THRESH   = 3'd4,
  parameter int         MIN_ROWS = 8,
  parameter int         WIN_W    = stereo_pkg::WIN_W,
  parameter int         WIN_H    = stereo_pkg::WIN_H,
  parameter int         DEPTH    = stereo_pkg::DEPTH
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  output logic [10:0] rdaddr,
  input  logic [2:0]  q_l,
  input  logic [2:0]  q_r,
  output logic        busy,
  output logic        done,
  output logic [11:0] disp_sum,
  output logic [4:0]  row_cnt,
  output logic        disp_valid
);
  import stereo_pkg::*;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [7:0]               drain_q, drain_d;
  logic signed [DISP_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     start_acc;
  tag_t                     issue;
  tag_t                     pipe_q [RD_LAT];
  tag_t                     smp;
  logic                     smp_last;
  logic                     found_l, found_r;
  logic [COL_W-1:0]         col_l, col_r;

  // Tag of the sample whose RAM data is on q_l/q_r this cycle.
  assign smp      = pipe_q[RD_LAT-1];
  assign smp_last = smp.vld && (smp.col == COL_W'(WIN_W-1));

  marker_find #(.THRESH(THRESH)) u_find_l (
    .sysclk(sysclk), .rst_n(rst_n), .clr_i(start_acc), .vld_i(smp.vld), .last_i(smp_last),
    .col_i(smp.col), .q_i(q_l), .found_o(found_l), .col_o(col_l)
  );

  marker_find #(.THRESH(THRESH)) u_find_r (
    .sysclk(sysclk), .rst_n(rst_n), .clr_i(start_acc), .vld_i(smp.vld), .last_i(smp_last),
    .col_i(smp.col), .q_i(q_r), .found_o(found_r), .col_o(col_r)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    row_d     = row_q;
    drain_d   = drain_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    start_acc = 1'b0;
    issue     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          start_acc = 1'b1;
          addr_d    = '0;
          col_d     = '0;
          row_d     = '0;
        end
      end
      SCAN: begin
        issue.vld = 1'b1;
        issue.col = col_q;
        issue.row = row_q;
        if (addr_q == ADDR_W'(DEPTH-1)) begin
          state_d = DRAIN;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (col_q == COL_W'(WIN_W-1)) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == 8'(RD_LAT-1)) state_d = DONE;
        else                         drain_d = drain_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_acc) begin
      sum_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (smp_last) begin
      if (found_l && found_r) begin
        sum_d = sum_q + disparity(col_l, col_r);
        cnt_d = cnt_q + 1'b1;
      end
      // Final row of the window lands on the same edge that enters DONE.
      if (smp.row == ROW_W'(WIN_H-1)) valid_d = (cnt_d >= CNT_W'(MIN_ROWS));
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      row_q     <= row_d;
      drain_q   <= drain_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rdaddr     = addr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign disp_sum   = sum_q;
  assign row_cnt    = cnt_q;
  assign disp_valid = valid_q;

endmodule

// File: tb/tb_stereo_disparity.sv
// Bench for stereo_disparity: behavioural 2-cycle RAMs plus a row-by-row reference model.
module tb_stereo_disparity;

  localparam int W = 79, H = 16, N = 1264, TH = 4;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic [10:0] rdaddr;
  logic [2:0]  q_l, q_r;
  logic        busy, done, disp_valid;
  logic [11:0] disp_sum;
  logic [4:0]  row_cnt;

  logic [2:0]  lmem [N];
  logic [2:0]  rmem [N];
  logic [10:0] a1 = '0, a2 = '0;
  int          n_checks = 0, n_fail = 0;

  always #5 sysclk = ~sysclk;

  // Calc RAMs with two cycles from address to data.
  always @(posedge sysclk) begin
    a1 <= rdaddr;
    a2 <= a1;
  end
  assign q_l = lmem[a2];
  assign q_r = rmem[a2];

  stereo_disparity #(.RD_LAT(2), .THRESH(3'd4), .MIN_ROWS(8)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .rdaddr(rdaddr), .q_l(q_l), .q_r(q_r),
    .busy(busy), .done(done), .disp_sum(disp_sum), .row_cnt(row_cnt), .disp_valid(disp_valid)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Background pixels stay below threshold.
  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      lmem[i] = 3'($urandom_range(0, TH - 1));
      rmem[i] = 3'($urandom_range(0, TH - 1));
    end
  endtask

  function automatic void model(output int sum, output int cnt);
    sum = 0;
    cnt = 0;
    for (int r = 0; r < H; r++) begin
      int cl = -1, cr = -1;
      for (int c = 0; c < W; c++) begin
        if (cl < 0 && int'(lmem[r*W+c]) >= TH) cl = c;
        if (cr < 0 && int'(rmem[r*W+c]) >= TH) cr = c;
      end
      if (cl >= 0 && cr >= 0) begin
        sum += cl - cr;
        cnt++;
      end
    end
  endfunction

  // Issues one start and observes 1400 cycles; start is re-pulsed during cycle mid_start.
  task automatic do_scan(input int mid_start, output int done_cyc, output int n_done, output int seq_err);
    @(negedge sysclk) start = 1'b1;
    @(posedge sysclk);
    #1 start = 1'b0;
    seq_err  = 0;
    n_done   = 0;
    done_cyc = -1;
    if (rdaddr !== 11'd0 || busy !== 1'b1) seq_err++;
    for (int cyc = 1; cyc <= 1400; cyc++) begin
      @(posedge sysclk);
      #1 start = (cyc == mid_start);
      if (rdaddr !== ((cyc <= N - 1) ? 11'(cyc) : 11'd0)) seq_err++;
      if (busy !== (cyc <= N + 2)) seq_err++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    n_checks++; if (rdaddr !== 11'd0) begin n_fail++; $display("FAIL reset rdaddr: got %0d want 0", rdaddr); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset busy_done: got %b%b want 00", busy, done); end
    n_checks++; if (disp_sum !== 12'd0 || row_cnt !== 5'd0 || disp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset results: got sum=%0d cnt=%0d valid=%b want 0 0 0", disp_sum, row_cnt, disp_valid);
    end
    @(negedge sysclk) rst_n = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    n_checks++; if (busy !== 1'b0 || rdaddr !== 11'd0) begin n_fail++; $display("FAIL idle_no_start: got busy=%b addr=%0d want 0 0", busy, rdaddr); end
  endtask

  task automatic test_all_rows();
    int dc, nd, se;
    clear_mem();
    for (int r = 0; r < H; r++) begin
      lmem[r*W+40] = 3'd4;
      rmem[r*W+30] = 3'd7;
    end
    do_scan(-1, dc, nd, se);
    n_checks++; if (dc !== 1266) begin n_fail++; $display("FAIL all_rows done_cycle: got %0d want 1266", dc); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL all_rows done_pulses: got %0d want 1", nd); end
    n_checks++; if (se !== 0) begin n_fail++; $display("FAIL all_rows addr_busy_seq: got %0d errors want 0", se); end
    n_checks++; if (int'($signed(disp_sum)) !== 160) begin n_fail++; $display("FAIL all_rows sum: got %0d want 160", $signed(disp_sum)); end
    n_checks++; if (row_cnt !== 5'd16) begin n_fail++; $display("FAIL all_rows cnt: got %0d want 16", row_cnt); end
    n_checks++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL all_rows valid: got %b want 1", disp_valid); end
  endtask

  task automatic test_negative();
    int dc, nd, se;
    clear_mem();
    for (int r = 0; r < H; r++) begin
      lmem[r*W+10] = 3'd5;
      if (r < 10) rmem[r*W+25] = 3'd4;
    end
    do_scan(-1, dc, nd, se);
    n_checks++; if (int'($signed(disp_sum)) !== -150) begin n_fail++; $display("FAIL negative sum: got %0d want -150", $signed(disp_sum)); end
    n_checks++; if (row_cnt !== 5'd10 || disp_valid !== 1'b1) begin
      n_fail++; $display("FAIL negative cnt_valid: got %0d/%b want 10/1", row_cnt, disp_valid);
    end
  endtask

  task automatic test_few_rows();
    int dc, nd, se;
    clear_mem();
    for (int r = 3; r < 8; r++) begin
      lmem[r*W+20] = 3'd6;
      rmem[r*W+18] = 3'd6;
    end
    do_scan(-1, dc, nd, se);
    n_checks++; if (int'($signed(disp_sum)) !== 10 || row_cnt !== 5'd5) begin
      n_fail++; $display("FAIL few_rows sum_cnt: got %0d/%0d want 10/5", $signed(disp_sum), row_cnt);
    end
    n_checks++; if (disp_valid !== 1'b0 || dc !== 1266) begin
      n_fail++; $display("FAIL few_rows valid_done: got %b/%0d want 0/1266", disp_valid, dc);
    end
  endtask

  task automatic test_col78();
    int dc, nd, se;
    clear_mem();
    lmem[3*W+78] = 3'd4;
    rmem[3*W+78] = 3'd4;
    do_scan(-1, dc, nd, se);
    n_checks++; if (row_cnt !== 5'd1 || disp_sum !== 12'd0) begin
      n_fail++; $display("FAIL col78 match: got cnt=%0d sum=%0d want 1 0", row_cnt, $signed(disp_sum));
    end
    // A left marker closing row 3 must not pair with a right marker opening row 4.
    clear_mem();
    lmem[3*W+78] = 3'd7;
    rmem[4*W+0]  = 3'd7;
    do_scan(-1, dc, nd, se);
    n_checks++; if (row_cnt !== 5'd0 || disp_sum !== 12'd0) begin
      n_fail++; $display("FAIL row_boundary: got cnt=%0d sum=%0d want 0 0", row_cnt, $signed(disp_sum));
    end
  endtask

  task automatic test_first_marker();
    int dc, nd, se;
    clear_mem();
    lmem[5*W+12] = 3'd4;
    lmem[5*W+50] = 3'd7;
    rmem[5*W+2]  = 3'd5;
    rmem[9*W+60] = 3'd4;
    rmem[9*W+70] = 3'd4;
    lmem[9*W+61] = 3'd4;
    do_scan(-1, dc, nd, se);
    n_checks++; if (int'($signed(disp_sum)) !== 11 || row_cnt !== 5'd2) begin
      n_fail++; $display("FAIL first_marker: got sum=%0d cnt=%0d want 11 2", $signed(disp_sum), row_cnt);
    end
  endtask

  task automatic test_start_while_busy();
    int dc, nd, se;
    clear_mem();
    for (int r = 0; r < H; r++) begin
      lmem[r*W+40] = 3'd4;
      rmem[r*W+30] = 3'd4;
    end
    do_scan(500, dc, nd, se);
    n_checks++; if (dc !== 1266 || nd !== 1) begin n_fail++; $display("FAIL busy_start done: got cyc=%0d pulses=%0d want 1266 1", dc, nd); end
    n_checks++; if (se !== 0 || int'($signed(disp_sum)) !== 160) begin
      n_fail++; $display("FAIL busy_start seq_sum: got err=%0d sum=%0d want 0 160", se, $signed(disp_sum));
    end
  endtask

  task automatic test_reset_mid_scan();
    int dc, nd, se, pulses;
    pulses = 0;
    @(negedge sysclk) start = 1'b1;
    @(posedge sysclk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 700; cyc++) begin
      @(posedge sysclk);
      #1 if (done === 1'b1) pulses++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rdaddr !== 11'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midscan_reset ctrl: got addr=%0d busy=%b done=%b want 0 0 0", rdaddr, busy, done);
    end
    n_checks++; if (disp_sum !== 12'd0 || row_cnt !== 5'd0 || disp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midscan_reset results: got %0d/%0d/%b want 0/0/0", disp_sum, row_cnt, disp_valid);
    end
    @(negedge sysclk) rst_n = 1'b1;
    for (int cyc = 0; cyc < 1400; cyc++) begin
      @(posedge sysclk);
      #1 if (done === 1'b1) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midscan_reset no_done: got %0d pulses want 0", pulses); end
    do_scan(-1, dc, nd, se);
    n_checks++; if (dc !== 1266 || se !== 0 || int'($signed(disp_sum)) !== 160 || row_cnt !== 5'd16) begin
      n_fail++; $display("FAIL after_reset scan: got cyc=%0d err=%0d sum=%0d cnt=%0d want 1266 0 160 16", dc, se, $signed(disp_sum), row_cnt);
    end
  endtask

  task automatic test_random();
    int dc, nd, se, esum, ecnt;
    for (int it = 0; it < 4; it++) begin
      clear_mem();
      for (int r = 0; r < H; r++) begin
        for (int k = 0; k < 2; k++) begin
          if ($urandom_range(0, 9) < 6) lmem[r*W + $urandom_range(0, W-1)] = 3'($urandom_range(TH, 7));
          if ($urandom_range(0, 9) < 6) rmem[r*W + $urandom_range(0, W-1)] = 3'($urandom_range(TH, 7));
        end
      end
      model(esum, ecnt);
      do_scan(-1, dc, nd, se);
      n_checks++; if (int'($signed(disp_sum)) !== esum || int'(row_cnt) !== ecnt) begin
        n_fail++; $display("FAIL random[%0d] sum_cnt: got %0d/%0d want %0d/%0d", it, $signed(disp_sum), row_cnt, esum, ecnt);
      end
      n_checks++; if (disp_valid !== (ecnt >= 8) || nd !== 1) begin
        n_fail++; $display("FAIL random[%0d] valid_done: got %b/%0d want %b/1", it, disp_valid, nd, (ecnt >= 8));
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_rows();
    test_negative();
    test_few_rows();
    test_col78();
    test_first_marker();
    test_start_while_busy();
    test_reset_mid_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stereo_disparity.md
STEREO_DISPARITY -- requirements
Module: stereo_disparity

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: calc-RAM read latency in sysclk cycles, from rdaddr to q.
REQ-002 SHALL have parameter THRESH, default 3'd4: a pixel is a marker when q >= THRESH.
REQ-003 SHALL have parameter MIN_ROWS, default 8: minimum matched rows for disp_valid.
REQ-004 SHALL have parameters WIN_W = 79, WIN_H = 16 and DEPTH = 1264: calc-window geometry.
REQ-005 sysclk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle request to scan both calc buffers; synchronous to sysclk.
REQ-008 rdaddr  out  11  shared read address to the left and right calc RAMs.
REQ-009 q_l  in  3  left calc-RAM read data.
REQ-010 q_r  in  3  right calc-RAM read data.
REQ-011 busy  out  1  high from scan start until done.
REQ-012 done  out  1  one-cycle pulse when results are final.
REQ-013 disp_sum  out  12  signed sum of per-row disparities (col_l - col_r).
REQ-014 row_cnt  out  5  number of matched rows, 0..16.
REQ-015 disp_valid  out  1  high when row_cnt >= MIN_ROWS; qualified by done and held afterwards.

Function
REQ-016 FSM states SHALL be IDLE, SCAN, DRAIN and DONE.
REQ-017 IDLE -> SCAN SHALL occur on start=1; that edge clears disp_sum, row_cnt and per-row state, and drives rdaddr=0.
REQ-018 In SCAN, rdaddr SHALL increment by 1 per cycle from 0 to 1263; SCAN -> DRAIN after 1263 is issued.
REQ-019 Column tag (0..78) and row tag (0..15) SHALL accompany each address through an RD_LAT-deep pipeline, so each q sample pairs with its own address.
REQ-020 Per row, col_l/col_r SHALL latch the first column with q_l/q_r >= THRESH; later markers in the same row SHALL be ignored.
REQ-021 On the column-78 sample of each row: if both sides found, disp_sum += col_l - col_r (signed) and row_cnt += 1; otherwise no change. Found flags then clear.
REQ-022 Negative disparity SHALL be accumulated with sign; the range of ±1248 fits in 12 bits, so no saturation is needed.
REQ-023 DRAIN SHALL last RD_LAT cycles and then go to DONE; DONE lasts one cycle, pulses done, then returns to IDLE.
REQ-024 done SHALL assert exactly 1264+RD_LAT cycles after the start edge.
REQ-025 start while busy SHALL be ignored, with no restart and no queueing.
REQ-026 disp_sum, row_cnt and disp_valid SHALL hold from done until the next accepted start.
REQ-027 rdaddr SHALL hold 0 outside SCAN.
REQ-028 A marker in column 78 SHALL count.
REQ-029 Row boundaries SHALL never merge: a marker in row r, column 78 must not affect row r+1.

Reset
REQ-030 rst_n low SHALL force IDLE, rdaddr=0, busy=0, done=0, disp_sum=0, row_cnt=0, disp_valid=0, and clear pipeline valid bits, immediately and independently of sysclk.
REQ-031 Reset mid-SCAN SHALL abort without a done pulse; the next start runs a full clean scan.

Structure
REQ-032 WIN_W, WIN_H, DEPTH, the state encoding and the disparity width (12) SHALL live in a shared package, stereo_pkg.
REQ-033 One sub-module, marker_find (per-camera first-marker latch plus found flag), SHALL be instantiated twice, once for q_l and once for q_r.

Verification
REQ-034 Left marker at column 40 and right at column 30 in all 16 rows, start -> done at cycle 1266 (RD_LAT=2), disp_sum=160, row_cnt=16, disp_valid=1.
REQ-035 Left at column 10 and right at column 25 in rows 0-9, no right marker in rows 10-15 -> disp_sum=-150, row_cnt=10, disp_valid=1.
REQ-036 Markers in only 5 rows (L=20, R=18) -> disp_sum=10, row_cnt=5, disp_valid=0.
REQ-037 Marker at column 78 in row 3 only, row 4 empty -> row 3 counts, row 4 not matched, row_cnt=1.
REQ-038 Second start at cycle 500 of a scan -> ignored, single done at cycle 1266; rst_n low at cycle 700 -> outputs 0, no done, and a subsequent start completes normally.
REQ-039 Two markers in one row (columns 12 and 50), other side at column 2 -> first-marker rule applies and that row's disparity is 10.
